// File: rtl/prf_alloc_ctrl_pkg.sv
// Shared sizing and state encoding for the PRF allocation controller.
package prf_alloc_ctrl_pkg;
  localparam int unsigned PRF_SIZE = 64;
  localparam int unsigned IW       = $clog2(PRF_SIZE);

  typedef enum logic {
    NORMAL,
    RECOVER
  } alloc_state_t;
endpackage

// File: rtl/prf_lowest_free_enc.sv
// Priority encoder: reports the lowest set bit of a free mask.
module prf_lowest_free_enc #(
  parameter int unsigned PRF_SIZE = prf_alloc_ctrl_pkg::PRF_SIZE,
  localparam int unsigned IW = $clog2(PRF_SIZE)
) (
  input  logic [PRF_SIZE-1:0] mask,
  output logic                found,
  output logic [IW-1:0]       idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < PRF_SIZE; i++) begin
      if (mask[i] && !found) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/prf_alloc_ctrl.sv
// PRF free-bitmap owner: dual rename grants, dual retirement frees, mispredict restore.
module prf_alloc_ctrl #(
  parameter int unsigned PRF_SIZE         = prf_alloc_ctrl_pkg::PRF_SIZE,
  parameter int unsigned RESERVED_ENTRIES = 0,
  localparam int unsigned IW = $clog2(PRF_SIZE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rat1_allocate_new_prf,
  input  logic                rat2_allocate_new_prf,
  input  logic                rrat1_prf_free_valid,
  input  logic [IW-1:0]       rrat1_prf_free_idx,
  input  logic                rrat2_prf_free_valid,
  input  logic [IW-1:0]       rrat2_prf_free_idx,
  input  logic                rrat_branch_mistaken_free_valid,
  input  logic [PRF_SIZE-1:0] rrat_prf_free_list,
  output logic                rat1_prf_rename_valid_out,
  output logic [IW-1:0]       rat1_prf_rename_idx_out,
  output logic                rat2_prf_rename_valid_out,
  output logic [IW-1:0]       rat2_prf_rename_idx_out,
  output logic [PRF_SIZE-1:0] prf_busy_list,
  output logic [IW:0]         prf_free_count,
  output logic                prf_stall,
  output logic                double_free_err
);
  import prf_alloc_ctrl_pkg::*;

  localparam logic [PRF_SIZE-1:0] LSB = PRF_SIZE'(1);
  // Shift overflows to zero when every entry is reserved, giving all-ones after -1.
  localparam logic [PRF_SIZE-1:0] RESET_BUSY  = (LSB << RESERVED_ENTRIES) - LSB;
  localparam logic [IW:0]         RESET_COUNT = (IW+1)'(PRF_SIZE - RESERVED_ENTRIES);
  localparam logic                RESET_STALL = (PRF_SIZE - RESERVED_ENTRIES) < 2;

  alloc_state_t        state_q, state_n;
  logic [PRF_SIZE-1:0] busy_q, busy_n, free_mask, mask2, grant_vec, free_vec;
  logic [IW:0]         count_q, count_n;
  logic                stall_q, err_q, err_n;
  logic                f1, f2, g1, g2, grant_en, free_en;
  logic [IW-1:0]       i1, i2;
  logic                eff1, eff2, dbl1, dbl2;

  assign free_mask = ~busy_q;
  assign grant_en  = !reset && (state_q == NORMAL) && !rrat_branch_mistaken_free_valid;
  assign free_en   = !rrat_branch_mistaken_free_valid;

  prf_lowest_free_enc #(.PRF_SIZE(PRF_SIZE)) u_enc1 (
    .mask (free_mask),
    .found(f1),
    .idx  (i1)
  );

  assign g1    = grant_en && rat1_allocate_new_prf && f1;
  assign mask2 = g1 ? (free_mask & ~(LSB << i1)) : free_mask;

  prf_lowest_free_enc #(.PRF_SIZE(PRF_SIZE)) u_enc2 (
    .mask (mask2),
    .found(f2),
    .idx  (i2)
  );

  assign g2 = grant_en && rat2_allocate_new_prf && f2;

  assign rat1_prf_rename_valid_out = g1;
  assign rat1_prf_rename_idx_out   = g1 ? i1 : '0;
  assign rat2_prf_rename_valid_out = g2;
  assign rat2_prf_rename_idx_out   = g2 ? i2 : '0;

  // Both RRATs freeing the same busy entry collapse into one free on port 1.
  assign eff1 = free_en && rrat1_prf_free_valid && busy_q[rrat1_prf_free_idx];
  assign eff2 = free_en && rrat2_prf_free_valid && busy_q[rrat2_prf_free_idx] &&
                !(rrat1_prf_free_valid && (rrat1_prf_free_idx == rrat2_prf_free_idx));
  assign dbl1 = free_en && rrat1_prf_free_valid && !busy_q[rrat1_prf_free_idx];
  assign dbl2 = free_en && rrat2_prf_free_valid && !busy_q[rrat2_prf_free_idx];

  always_comb begin
    grant_vec = '0;
    free_vec  = '0;
    if (g1)   grant_vec = grant_vec | (LSB << i1);
    if (g2)   grant_vec = grant_vec | (LSB << i2);
    if (eff1) free_vec  = free_vec  | (LSB << rrat1_prf_free_idx);
    if (eff2) free_vec  = free_vec  | (LSB << rrat2_prf_free_idx);

    busy_n  = (busy_q | grant_vec) & ~free_vec;
    state_n = state_q;
    count_n = count_q;
    err_n   = err_q | dbl1 | dbl2;

    case (state_q)
      NORMAL: begin
        if (rrat_branch_mistaken_free_valid) begin
          busy_n  = ~rrat_prf_free_list;
          state_n = RECOVER;
        end else begin
          count_n = count_q - (IW+1)'(g1) - (IW+1)'(g2)
                            + (IW+1)'(eff1) + (IW+1)'(eff2);
        end
      end
      RECOVER: begin
        if (rrat_branch_mistaken_free_valid) busy_n = ~rrat_prf_free_list;
        else                                 state_n = NORMAL;
        count_n = (IW+1)'($countones(~busy_n));
      end
      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= NORMAL;
      busy_q  <= RESET_BUSY;
      count_q <= RESET_COUNT;
      stall_q <= RESET_STALL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= busy_n;
      count_q <= count_n;
      stall_q <= (count_n < (IW+1)'(2)) || (state_n == RECOVER);
      err_q   <= err_n;
    end
  end

  assign prf_busy_list   = busy_q;
  assign prf_free_count  = count_q;
  assign prf_stall       = stall_q;
  assign double_free_err = err_q;
endmodule

// File: tb/tb_prf_alloc_ctrl.sv
// Scoreboard bench for prf_alloc_ctrl with PRF_SIZE=64, RESERVED_ENTRIES=0.
module tb_prf_alloc_ctrl;
  localparam int unsigned N  = 64;
  localparam int unsigned IW = 6;

  typedef struct packed {
    logic          v1;
    logic [IW-1:0] i1;
    logic          v2;
    logic [IW-1:0] i2;
  } grant_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rat1_req = 1'b0, rat2_req = 1'b0;
  logic          f1v = 1'b0, f2v = 1'b0;
  logic [IW-1:0] f1i = '0, f2i = '0;
  logic          mis = 1'b0;
  logic [N-1:0]  free_list = '0;
  logic          v1_o, v2_o, stall_o, err_o;
  logic [IW-1:0] i1_o, i2_o;
  logic [N-1:0]  busy_o;
  logic [IW:0]   count_o;

  grant_t exp_q[$];
  int     tests_run    = 0;
  int     tests_failed = 0;

  always #5 clock = ~clock;

  prf_alloc_ctrl #(.PRF_SIZE(N), .RESERVED_ENTRIES(0)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .rat1_allocate_new_prf          (rat1_req),
    .rat2_allocate_new_prf          (rat2_req),
    .rrat1_prf_free_valid           (f1v),
    .rrat1_prf_free_idx             (f1i),
    .rrat2_prf_free_valid           (f2v),
    .rrat2_prf_free_idx             (f2i),
    .rrat_branch_mistaken_free_valid(mis),
    .rrat_prf_free_list             (free_list),
    .rat1_prf_rename_valid_out      (v1_o),
    .rat1_prf_rename_idx_out        (i1_o),
    .rat2_prf_rename_valid_out      (v2_o),
    .rat2_prf_rename_idx_out        (i2_o),
    .prf_busy_list                  (busy_o),
    .prf_free_count                 (count_o),
    .prf_stall                      (stall_o),
    .double_free_err                (err_o)
  );

  function automatic grant_t observed();
    return '{v1: v1_o, i1: i1_o, v2: v2_o, i2: i2_o};
  endfunction

  // Drive one cycle of stimulus, queue its expected grants, move to the sample point.
  task automatic issue(input logic r1, input logic r2,
                       input logic a_v, input logic [IW-1:0] a_i,
                       input logic b_v, input logic [IW-1:0] b_i,
                       input logic m, input grant_t e);
    rat1_req = r1; rat2_req = r2;
    f1v = a_v; f1i = a_i; f2v = b_v; f2i = b_i;
    mis = m;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    rat1_req = 1'b0; rat2_req = 1'b0; f1v = 1'b0; f2v = 1'b0; mis = 1'b0;
  endtask

  task automatic test_reset();
    grant_t e, g;
    reset = 1'b1;
    issue(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL reset_grants: got %h expected %h", g, e); end
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (count_o !== 7'd64) begin tests_failed++; $display("FAIL reset_count: got %0d expected 64", count_o); end
    tests_run++;
    if (busy_o !== '0) begin tests_failed++; $display("FAIL reset_busy: got %h expected 0", busy_o); end
    tests_run++;
    if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    tests_run++;
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_o); end
  endtask

  task automatic test_single_alloc();
    grant_t e, g;
    grant_t exp_tab[3];
    logic   req_tab[3];
    exp_tab = '{'{1'b1, 6'd0, 1'b0, 6'd0}, '{1'b1, 6'd1, 1'b0, 6'd0}, '0};
    req_tab = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      issue(req_tab[k], 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, exp_tab[k]);
      e = exp_q.pop_front(); g = observed(); tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL single_alloc[%0d]: got %h expected %h", k, g, e); end
      if (k == 2) begin
        tests_run++;
        if (count_o !== 7'd62) begin tests_failed++; $display("FAIL single_count: got %0d expected 62", count_o); end
      end
      tick();
    end
  endtask

  task automatic test_dual_alloc();
    grant_t e, g;
    issue(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '{1'b1, 6'd2, 1'b1, 6'd3});
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL dual_alloc: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd60) begin tests_failed++; $display("FAIL dual_count: got %0d expected 60", count_o); end
  endtask

  task automatic test_free_reuse();
    grant_t e, g;
    issue(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, '0, 1'b0, '{1'b1, 6'd4, 1'b0, 6'd0});
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL free_same_cycle: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd60) begin tests_failed++; $display("FAIL free_count: got %0d expected 60", count_o); end
    issue(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '{1'b1, 6'd0, 1'b0, 6'd0});
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL reuse_next_cycle: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd59) begin tests_failed++; $display("FAIL reuse_count: got %0d expected 59", count_o); end
  endtask

  task automatic test_back_to_back_exhaustion();
    grant_t e, g;
    for (int k = 0; k < 29; k++) begin
      issue(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0,
            '{1'b1, IW'(5 + 2 * k), 1'b1, IW'(6 + 2 * k)});
      e = exp_q.pop_front(); g = observed(); tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL b2b_alloc[%0d]: got %h expected %h", k, g, e); end
      tick();
    end
    tests_run++;
    if (count_o !== 7'd1) begin tests_failed++; $display("FAIL exhaust_count1: got %0d expected 1", count_o); end
    tests_run++;
    if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL exhaust_stall1: got %b expected 1", stall_o); end
    issue(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '{1'b1, 6'd63, 1'b0, 6'd0});
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL last_entry: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd0) begin tests_failed++; $display("FAIL exhaust_count0: got %0d expected 0", count_o); end
    issue(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL empty_grants: got %h expected %h", g, e); end
    tick();
  endtask

  task automatic test_mispredict();
    grant_t e, g;
    free_list = 64'hFFFF_FFFF_FFFF_FFF0;
    issue(1'b1, 1'b1, 1'b1, 6'd20, 1'b0, '0, 1'b1, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL mispredict_grants: got %h expected %h", g, e); end
    tick();
    issue(1'b1, 1'b0, 1'b1, 6'd3, 1'b0, '0, 1'b0, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL recover_grants: got %h expected %h", g, e); end
    tests_run++;
    if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL recover_stall: got %b expected 1", stall_o); end
    tests_run++;
    if (busy_o !== 64'hF) begin tests_failed++; $display("FAIL recover_busy: got %h expected f", busy_o); end
    tick();
    tests_run++;
    if (count_o !== 7'd61) begin tests_failed++; $display("FAIL recover_count: got %0d expected 61", count_o); end
    tests_run++;
    if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL post_recover_stall: got %b expected 0", stall_o); end
    tests_run++;
    if (busy_o !== 64'h7) begin tests_failed++; $display("FAIL post_recover_busy: got %h expected 7", busy_o); end
    issue(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '{1'b1, 6'd3, 1'b0, 6'd0});
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL post_recover_grant: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd60) begin tests_failed++; $display("FAIL post_recover_count: got %0d expected 60", count_o); end
  endtask

  task automatic test_same_idx_free();
    grant_t e, g;
    issue(1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 6'd1, 1'b0, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL same_idx_grants: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (count_o !== 7'd61) begin tests_failed++; $display("FAIL same_idx_count: got %0d expected 61", count_o); end
    tests_run++;
    if (err_o !== 1'b0) begin tests_failed++; $display("FAIL same_idx_err: got %b expected 0", err_o); end
    tests_run++;
    if (busy_o !== 64'hD) begin tests_failed++; $display("FAIL same_idx_busy: got %h expected d", busy_o); end
  endtask

  task automatic test_double_free();
    grant_t e, g;
    issue(1'b0, 1'b0, 1'b0, '0, 1'b1, 6'd10, 1'b0, '0);
    e = exp_q.pop_front(); g = observed(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL double_free_grants: got %h expected %h", g, e); end
    tick();
    tests_run++;
    if (err_o !== 1'b1) begin tests_failed++; $display("FAIL double_free_err: got %b expected 1", err_o); end
    tests_run++;
    if (count_o !== 7'd61) begin tests_failed++; $display("FAIL double_free_count: got %0d expected 61", count_o); end
    repeat (2) tick();
    tests_run++;
    if (err_o !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err_o); end
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_dual_alloc();
    test_free_reuse();
    test_back_to_back_exhaustion();
    test_mispredict();
    test_same_idx_free();
    test_double_free();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/prf_alloc_ctrl.md
Name: prf_alloc_ctrl

Overview:
Allocation controller for the physical register file: owns the PRF free bitmap and grants up to two new PRF entries per cycle to RAT1/RAT2 rename requests.
Reclaims entries on RRAT retirement (two per cycle).
Restores the free bitmap from the RRAT on branch mispredict, through a one-cycle recovery state.
Sits between the RATs/RRAT and the prf datapath; the busy list it exports drives PRF valid-bit clearing.

Parameters:
PRF_SIZE, 64, number of physical registers (power of two); idx width IW = $clog2(PRF_SIZE)
RESERVED_ENTRIES, 0, entries [0, RESERVED_ENTRIES) marked busy at reset (initial architectural mappings)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rat1_allocate_new_prf  in  1  RAT1 requests one new PRF entry this cycle
rat2_allocate_new_prf  in  1  RAT2 requests one new PRF entry this cycle
rrat1_prf_free_valid  in  1  RRAT1 retirement frees rrat1_prf_free_idx
rrat1_prf_free_idx  in  IW  entry freed by RRAT1
rrat2_prf_free_valid  in  1  RRAT2 retirement frees rrat2_prf_free_idx
rrat2_prf_free_idx  in  IW  entry freed by RRAT2
rrat_branch_mistaken_free_valid  in  1  mispredict; load the free bitmap from rrat_prf_free_list
rrat_prf_free_list  in  PRF_SIZE  bit i = 1 means entry i is free after recovery
rat1_prf_rename_valid_out  out  1  RAT1 grant valid (combinational, same cycle)
rat1_prf_rename_idx_out  out  IW  RAT1 granted entry
rat2_prf_rename_valid_out  out  1  RAT2 grant valid
rat2_prf_rename_idx_out  out  IW  RAT2 granted entry
prf_busy_list  out  PRF_SIZE  registered; bit i = 1 means entry i is allocated
prf_free_count  out  IW+1  registered count of free entries
prf_stall  out  1  registered; 1 when prf_free_count < 2 or state == RECOVER
double_free_err  out  1  sticky; set when a free targets an already-free entry

Behaviour:
- Reset (synchronous, priority over every other input):
  - state = NORMAL
  - busy bits [0, RESERVED_ENTRIES) = 1, all other bits = 0
  - prf_free_count = PRF_SIZE - RESERVED_ENTRIES
  - double_free_err = 0
  - prf_stall = (count < 2)
  - grant outputs are 0 during reset
- States: NORMAL, RECOVER.
- NORMAL grants:
  - RAT1 receives the lowest-index free entry.
  - RAT2 receives the lowest-index free entry excluding RAT1's grant when RAT1 requested and was granted; otherwise the lowest-index free entry.
  - A grant is valid only when requested and an entry exists. With one free entry and both requesting, RAT1 wins and RAT2's valid = 0.
  - When a grant is not valid, its idx_out = 0.
- Bitmap update at posedge: busy |= granted entries; busy &= ~(effective frees).
  - Frees made in cycle N are allocatable from cycle N+1, never in the same cycle.
- Effective free: valid && busy[idx] == 1.
  - valid && busy[idx] == 0: no change; double_free_err <= 1.
  - rrat1 and rrat2 freeing the same idx in one cycle counts as one free and is not an error.
- Counter: count_next = count - grants + effective frees, range 0..PRF_SIZE, never wraps.
  - Grants are impossible at count 0.
  - Frees cannot exceed the number of busy entries, because only busy bits count.
- Mispredict (rrat_branch_mistaken_free_valid = 1 in NORMAL):
  - That cycle: both grant valids forced to 0; retirement frees and allocation requests are ignored.
  - Next posedge: busy <= ~rrat_prf_free_list, state <= RECOVER.
- RECOVER (exactly one cycle):
  - Grant valids = 0.
  - prf_free_count <= popcount(~busy); retirement frees are applied to the bitmap and included in the count.
  - Mispredict asserted again: stays in RECOVER and reloads the list.
  - Otherwise returns to NORMAL.
- double_free_err is cleared only by reset.

Decomposition:
- Shared package entries:
  - PRF_SIZE
  - IW
  - alloc_state_t enum {NORMAL, RECOVER}
- One natural sub-module: prf_lowest_free_enc.
  - Parameterised priority encoder with a PRF_SIZE-bit mask input, producing found + idx.
  - Instantiated twice; the second copy takes the mask with RAT1's grant removed.

Test Plan:
- Reset: hold reset for 2 cycles, release. Required with PRF_SIZE=64, RESERVED_ENTRIES=0: count = 64, busy_list = 0, stall = 0, err = 0.
- Single allocation:
  - rat1 request → idx 0, valid 1.
  - Next cycle, rat1 request → idx 1.
  - Idle cycle → both valids 0; count = 62.
- Dual allocation: both request → rat1 idx 2, rat2 idx 3; count drops by 2.
- Free then reuse:
  - rrat1 frees idx 0 while rat1 requests → rat1 receives idx 4 in that cycle.
  - Next cycle, rat1 request → idx 0.
- Exhaustion:
  - Allocate until count = 1 → stall = 1.
  - Both request → rat1 valid with the last free idx, rat2 valid 0.
  - Then count = 0 → both valids 0.
- Mispredict, double free, and same-idx dual free:
  - Mispredict with free_list = 64'hFFFF_FFFF_FFFF_FFF0 → grants 0 that cycle; next cycle RECOVER (valids 0, stall 1); count = 60 the cycle after.
  - rrat2 frees an already-free idx 10 → double_free_err = 1 and stays 1.
  - rrat1 and rrat2 free the same busy idx in one cycle → count +1, err unchanged.
